// File: rtl/color_sense_ctrl.sv
// Colour-sensor measurement controller: steps the sensor filter select through the
// enabled filters, counts sensor edges over a fixed gate and stores per-sensor results.
module color_sense_ctrl #(
    parameter int NUM_SENSORS   = 2,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 1000,
    parameter int GATE_CYCLES   = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] in_sq,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [3:0]             filter_mask,
    output logic [1:0]             s_ctrl,
    output logic                   get_it,
    output logic                   busy,
    input  logic [1:0]             rd_sensor,
    input  logic [1:0]             rd_filter,
    output logic [CNT_W-1:0]       rd_data,
    output logic                   rd_ovf
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_GATE   = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Returns {found, code} for the lowest enabled filter code >= from.
    function automatic logic [2:0] first_enabled(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int j = 3; j >= 0; j--) begin
            if (mask[j] && (3'(j) >= from)) begin
                res = {1'b1, 2'(j)};
            end
        end
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [1:0]               s_ctrl_q, s_ctrl_d;
    logic [3:0]               mask_q, mask_d;
    logic                     get_it_q, busy_q;
    logic [NUM_SENSORS-1:0]   sync1_q, sync2_q, prev_q;
    logic [NUM_SENSORS-1:0]   edge_s;
    logic [CNT_W-1:0]         cnt_q [NUM_SENSORS];
    logic [NUM_SENSORS-1:0]   cov_q;
    logic [CNT_W-1:0]         res_q [NUM_SENSORS][4];
    logic [3:0]               rovf_q [NUM_SENSORS];
    logic [CNT_W-1:0]         rd_data_q, rd_data_d;
    logic                     rd_ovf_q, rd_ovf_d;
    logic [2:0]               first_s, next_s;

    assign edge_s  = sync2_q & ~prev_q;
    assign s_ctrl  = s_ctrl_q;
    assign get_it  = get_it_q;
    assign busy    = busy_q;
    assign rd_data = rd_data_q;
    assign rd_ovf  = rd_ovf_q;

    // Sequencer next-state logic.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        s_ctrl_d = s_ctrl_q;
        mask_d   = mask_q;
        first_s  = first_enabled(filter_mask, 3'd0);
        next_s   = first_enabled(mask_q, {1'b0, s_ctrl_q} + 3'd1);
        case (state_q)
            ST_IDLE: begin
                if (start && first_s[2]) begin
                    state_d  = ST_SETTLE;
                    tmr_d    = '0;
                    s_ctrl_d = first_s[1:0];
                    mask_d   = filter_mask;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_GATE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_GATE: begin
                if (tmr_q == TMR_W'(GATE_CYCLES - 1)) begin
                    state_d = ST_STORE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_STORE: begin
                if (next_s[2]) begin
                    state_d  = ST_SETTLE;
                    s_ctrl_d = next_s[1:0];
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (continuous && first_s[2]) begin
                    state_d  = ST_SETTLE;
                    s_ctrl_d = first_s[1:0];
                    mask_d   = filter_mask;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            s_ctrl_q <= 2'b00;
            mask_q   <= 4'b0000;
            get_it_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            s_ctrl_q <= s_ctrl_d;
            mask_q   <= mask_d;
            get_it_q <= (state_d == ST_DONE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Read mux; a same-cycle STORE to the addressed entry is forwarded.
    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int s = 0; s < NUM_SENSORS; s++) begin
            if (rd_sensor == 2'(s)) begin
                if ((state_q == ST_STORE) && (rd_filter == s_ctrl_q)) begin
                    rd_data_d = cnt_q[s];
                    rd_ovf_d  = cov_q[s];
                end else begin
                    rd_data_d = res_q[s][rd_filter];
                    rd_ovf_d  = rovf_q[s][rd_filter];
                end
            end else begin
                rd_data_d = rd_data_d;
                rd_ovf_d  = rd_ovf_d;
            end
        end
    end

    // Input synchronisers, edge counters, result array and read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cov_q     <= '0;
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
            for (int s = 0; s < NUM_SENSORS; s++) begin
                cnt_q[s]  <= '0;
                rovf_q[s] <= 4'b0000;
                for (int f = 0; f < 4; f++) begin
                    res_q[s][f] <= '0;
                end
            end
        end else begin
            sync1_q   <= in_sq;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rd_data_q <= rd_data_d;
            rd_ovf_q  <= rd_ovf_d;
            for (int s = 0; s < NUM_SENSORS; s++) begin
                if (state_q == ST_SETTLE) begin
                    cnt_q[s] <= '0;
                    cov_q[s] <= 1'b0;
                end else if ((state_q == ST_GATE) && edge_s[s]) begin
                    if (cnt_q[s] == CNT_MAX) begin
                        cov_q[s] <= 1'b1;
                    end else begin
                        cnt_q[s] <= cnt_q[s] + 1'b1;
                    end
                end
                if (state_q == ST_STORE) begin
                    res_q[s][s_ctrl_q]  <= cnt_q[s];
                    rovf_q[s][s_ctrl_q] <= cov_q[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_color_sense_ctrl.sv
// Directed bench for color_sense_ctrl: sequencing, timing, counting, saturation,
// continuous mode, ignored starts and mid-gate reset, with table-driven readback.
module tb_color_sense_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_sq, in_sq2;
    logic       start, start2, continuous;
    logic [3:0] filter_mask, filter_mask2;
    logic [1:0] s_ctrl, s_ctrl2;
    logic       get_it, get_it2, busy, busy2;
    logic [1:0] rd_sensor, rd_filter, rd_sensor2, rd_filter2;
    logic [7:0] rd_data, rd_data2;
    logic       rd_ovf, rd_ovf2;

    int n_checks = 0;
    int n_err    = 0;
    bit sq_mode  = 1'b0;
    bit tog2     = 1'b0;

    typedef struct {
        logic [1:0] s;
        logic [1:0] f;
        int         lo;
        int         hi;
        int         ovf;
    } vec_t;
    vec_t tv [16];

    always #5 clk = ~clk;

    color_sense_ctrl #(.NUM_SENSORS(2), .CNT_W(8), .SETTLE_CYCLES(4), .GATE_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .in_sq(in_sq), .start(start), .continuous(continuous),
        .filter_mask(filter_mask), .s_ctrl(s_ctrl), .get_it(get_it), .busy(busy),
        .rd_sensor(rd_sensor), .rd_filter(rd_filter), .rd_data(rd_data), .rd_ovf(rd_ovf)
    );

    color_sense_ctrl #(.NUM_SENSORS(2), .CNT_W(8), .SETTLE_CYCLES(4), .GATE_CYCLES(600)) dut2 (
        .clk(clk), .reset(reset), .in_sq(in_sq2), .start(start2), .continuous(1'b0),
        .filter_mask(filter_mask2), .s_ctrl(s_ctrl2), .get_it(get_it2), .busy(busy2),
        .rd_sensor(rd_sensor2), .rd_filter(rd_filter2), .rd_data(rd_data2), .rd_ovf(rd_ovf2)
    );

    // Square-wave sources: periods 10/20 for dut, toggle-every-clock for dut2.
    initial begin
        int gcnt;
        gcnt   = 0;
        in_sq  = 2'b00;
        in_sq2 = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            gcnt++;
            if (sq_mode) begin
                in_sq[0] = ((gcnt % 10) < 5);
                in_sq[1] = ((gcnt % 20) < 10);
            end else begin
                in_sq = 2'b00;
            end
            in_sq2[0] = tog2 ? ~in_sq2[0] : 1'b0;
            in_sq2[1] = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < 16; i++) begin
            rd_sensor = tv[i].s;
            rd_filter = tv[i].f;
            step();
            chk($sformatf("rd_data[%0d][%0d]", tv[i].s, tv[i].f), int'(rd_data), tv[i].lo, tv[i].hi);
            chk($sformatf("rd_ovf[%0d][%0d]", tv[i].s, tv[i].f), int'(rd_ovf), tv[i].ovf, tv[i].ovf);
        end
    endtask

    initial begin
        int pulses;
        int pulse_k;
        int ptimes [4];
        int done_k;

        reset = 1'b1; start = 1'b1; continuous = 1'b0; filter_mask = 4'hF;
        rd_sensor = 2'd0; rd_filter = 2'd0;
        start2 = 1'b0; filter_mask2 = 4'h0; rd_sensor2 = 2'd0; rd_filter2 = 2'd0;
        repeat (3) step();
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_s_ctrl", int'(s_ctrl), 0, 0);
        chk("reset_get_it", int'(get_it), 0, 0);
        chk("reset_rd_data", int'(rd_data), 0, 0);
        chk("reset_busy2", int'(busy2), 0, 0);
        start = 1'b0; reset = 1'b0;
        sq_mode = 1'b1;
        repeat (20) step();

        // Full four-filter set; a start during GATE and a mask change must be ignored.
        filter_mask = 4'hF; start = 1'b1;
        step();
        start = 1'b0; filter_mask = 4'b0001;
        chk("t1_busy_k1", int'(busy), 1, 1);
        pulses = 0; pulse_k = 0;
        for (int k = 1; k <= 425; k++) begin
            if (get_it) begin
                pulses++;
                pulse_k = k;
            end
            case (k)
                1, 106, 211, 316: chk($sformatf("t1_s_ctrl_k%0d", k), int'(s_ctrl), (k - 1) / 105, (k - 1) / 105);
                104:     chk("t1_rd_old", int'(rd_data), 0, 0);
                106:     chk("t1_rd_store_fwd", int'(rd_data), 9, 11);
                421:     chk("t1_busy_done", int'(busy), 1, 1);
                422:     chk("t1_busy_idle", int'(busy), 0, 0);
                default: ;
            endcase
            start = (k == 50);
            step();
        end
        chk("t1_get_it_count", pulses, 1, 1);
        chk("t1_get_it_cycle", pulse_k, 421, 421);
        chk("t1_s_ctrl_hold", int'(s_ctrl), 3, 3);

        for (int i = 0; i < 16; i++) begin
            tv[i].s   = 2'(i / 4);
            tv[i].f   = 2'(i % 4);
            tv[i].ovf = 0;
            tv[i].lo  = (i < 4) ? 9 : (i < 8) ? 4 : 0;
            tv[i].hi  = (i < 4) ? 11 : (i < 8) ? 6 : 0;
        end
        run_table();

        // Continuous mode on filter 0 with no edges; drop continuous in the third GATE.
        sq_mode = 1'b0;
        repeat (5) step();
        filter_mask = 4'b0001; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 345; k++) begin
            if (get_it) begin
                if (pulses < 4) ptimes[pulses] = k;
                pulses++;
            end
            if (k == 319) chk("t3_busy_after", int'(busy), 0, 0);
            if (k == 250) continuous = 1'b0;
            step();
        end
        chk("t3_get_it_count", pulses, 3, 3);
        chk("t3_pulse0", ptimes[0], 106, 106);
        chk("t3_pulse1", ptimes[1], 212, 212);
        chk("t3_pulse2", ptimes[2], 318, 318);
        tv[0].lo = 0; tv[0].hi = 0;
        tv[4].lo = 0; tv[4].hi = 0;
        run_table();

        // Start with an empty mask is ignored.
        filter_mask = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_busy_k1", int'(busy), 0, 0);
        repeat (5) step();
        chk("t5_busy_k6", int'(busy), 0, 0);
        chk("t5_get_it", int'(get_it), 0, 0);

        // Reset in the middle of GATE on filter 1.
        sq_mode = 1'b1;
        filter_mask = 4'b0010; start = 1'b1;
        step();
        start = 1'b0;
        repeat (59) step();
        chk("t4_s_ctrl_gate", int'(s_ctrl), 1, 1);
        chk("t4_busy_gate", int'(busy), 1, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_busy_rst", int'(busy), 0, 0);
        chk("t4_s_ctrl_rst", int'(s_ctrl), 0, 0);
        chk("t4_get_it_rst", int'(get_it), 0, 0);
        pulses = 0;
        for (int k = 0; k < 200; k++) begin
            if (get_it) pulses++;
            step();
        end
        chk("t4_no_get_it", pulses, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tv[i].lo = 0; tv[i].hi = 0; tv[i].ovf = 0;
        end
        run_table();

        // Saturation on dut2: 300 edges in a 600-cycle gate on filter 2.
        tog2 = 1'b1;
        repeat (5) step();
        filter_mask2 = 4'b0100; start2 = 1'b1;
        step();
        start2 = 1'b0;
        done_k = 0;
        for (int k = 1; k <= 700 && done_k == 0; k++) begin
            if (get_it2) done_k = k;
            else step();
        end
        chk("t2_done_cycle", done_k, 606, 606);
        rd_sensor2 = 2'd0; rd_filter2 = 2'd2; step();
        chk("t2_rd_sat", int'(rd_data2), 255, 255);
        chk("t2_ovf_sat", int'(rd_ovf2), 1, 1);
        rd_sensor2 = 2'd1; rd_filter2 = 2'd2; step();
        chk("t2_rd_s1", int'(rd_data2), 0, 0);
        chk("t2_ovf_s1", int'(rd_ovf2), 0, 0);
        rd_sensor2 = 2'd0; rd_filter2 = 2'd0; step();
        chk("t2_rd_f0", int'(rd_data2), 0, 0);
        chk("t2_ovf_f0", int'(rd_ovf2), 0, 0);
        rd_sensor2 = 2'd2; rd_filter2 = 2'd2; step();
        chk("t2_rd_oob", int'(rd_data2), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
